frac_div_multi: RTL

- Multi-channel, runtime-programmable fractional clock divider (phase-accumulator NCO).
- Generalises the fixed single-channel divider: N independent channels, per-channel enable, glitch-free increment reload over a valid/ready port, and a common phase-sync input.
- Outputs per channel: a ~50% duty square wave and a one-cycle tick strobe.
- Sits beside UART/SPI/LED blocks as their baud/bit-rate source, replacing per-instance fixed dividers.

---
 rtl/frac_div_multi_pkg.sv | 41 ++++
 rtl/frac_div_chan.sv | 79 +++++++
 rtl/frac_div_multi.sv | 119 +++++++++++
 3 files changed

// File: rtl/frac_div_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frac_div_multi_pkg
// Purpose  : Shared definitions for the multi-channel fractional divider:
//            reload-handshake state encoding plus helpers for users sizing
//            the cfg_chan field and computing increments from frequencies.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package frac_div_multi_pkg;

    // Reload handshake states (explicit 2-bit encoding)
    localparam logic [1:0] CFG_IDLE = 2'd0;  // slot free, cfg_ready high
    localparam logic [1:0] CFG_PEND = 2'd1;  // value held, waiting for a legal apply point
    localparam logic [1:0] CFG_DONE = 2'd2;  // applied or discarded; ready returns next edge

    // Minimum cfg_chan width for a given channel count: 2**result >= value.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    // Rounded increment for a target output frequency:
    // incr = round(f_out * 2**width / f_clk).
    function automatic longint unsigned frac_div_incr(
        input longint unsigned f_out_hz,
        input longint unsigned f_clk_hz,
        input int unsigned     width
    );
        return ((f_out_hz << width) + (f_clk_hz >> 1)) / f_clk_hz;
    endfunction

endpackage : frac_div_multi_pkg
`default_nettype wire

// File: rtl/frac_div_chan.sv
`default_nettype none
// ============================================================================
// Module   : frac_div_chan
// Purpose  : One phase-accumulator channel. Adds its increment each enabled
//            edge; the carry becomes a one-cycle tick and the new MSB the
//            square output. Reports when an increment reload may be applied
//            without producing a runt/stretched interval.
// Ports    : clk, reset    - clock, async active-high reset
//            en            - accumulate enable
//            sync          - zero accumulator and outputs this edge
//            ld, ld_incr   - load ld_incr into the increment register
//            tick, out     - registered carry strobe / square wave
//            wrap_ok       - this edge is a legal increment apply point
// Revision : 1.0 - initial release
// ============================================================================
module frac_div_chan
    import frac_div_multi_pkg::*;
#(
    parameter int Width = 22,
    parameter int Incr  = 19327
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             ld,
    input  logic [Width-1:0] ld_incr,
    output logic             tick,
    output logic             out,
    output logic             wrap_ok
);

    logic [Width-1:0] acc_q,  acc_d;
    logic [Width-1:0] incr_q, incr_d;
    logic             tick_q, tick_d;
    logic             out_q,  out_d;
    logic [Width:0]   sum;

    always_comb begin
        // One extra bit so the carry falls out of the add
        sum    = {1'b0, acc_q} + {1'b0, incr_q};
        acc_d  = acc_q;
        tick_d = 1'b0;
        out_d  = out_q;
        incr_d = ld ? ld_incr : incr_q;

        if (sync) begin
            acc_d = '0;
            out_d = 1'b0;
        end else if (en) begin
            acc_d  = sum[Width-1:0];
            tick_d = sum[Width];
            out_d  = sum[Width-1];
        end
    end

    // Apply points: the carry edge (new incr starts a fresh interval), a sync,
    // or whenever the channel is not advancing at all.
    assign wrap_ok = sync | ~en | (incr_q == '0) | sum[Width];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            incr_q <= Width'(Incr);
            tick_q <= 1'b0;
            out_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            incr_q <= incr_d;
            tick_q <= tick_d;
            out_q  <= out_d;
        end
    end

    assign tick = tick_q;
    assign out  = out_q;

endmodule : frac_div_chan
`default_nettype wire

// File: rtl/frac_div_multi.sv
`default_nettype none
// ============================================================================
// Module   : frac_div_multi
// Purpose  : Multi-channel runtime-programmable fractional clock divider
//            (phase-accumulator NCO). Channels run independently; a single
//            shared pending slot takes increment reloads over valid/ready and
//            applies them glitch-free at the target channel's wrap point.
// Ports    : clk, reset              - clock, async active-high reset
//            en[Channels]            - per-channel accumulate enable
//            sync                    - zero every accumulator next edge
//            cfg_valid/cfg_ready     - reload handshake
//            cfg_chan, cfg_incr      - reload target and value
//            out[Channels]           - ~50% duty square outputs
//            tick[Channels]          - one-cycle carry strobes
// Revision : 1.0 - initial release
// ============================================================================
module frac_div_multi
    import frac_div_multi_pkg::*;
#(
    parameter int Width    = 22,
    parameter int Incr     = 19327,
    parameter int Channels = 2,
    parameter int ChanBits = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [Channels-1:0] en,
    input  logic                sync,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [ChanBits-1:0] cfg_chan,
    input  logic [Width-1:0]    cfg_incr,
    output logic [Channels-1:0] out,
    output logic [Channels-1:0] tick
);

    logic [1:0]          state_q, state_d;
    logic [ChanBits-1:0] pend_chan_q, pend_chan_d;
    logic [Width-1:0]    pend_incr_q, pend_incr_d;
    logic [Channels-1:0] wrap_ok;
    logic [Channels-1:0] ld;
    logic                chan_ok;
    logic                xfer;
    logic                apply;

    // Out-of-range targets are accepted but never reach the pending slot
    assign chan_ok = 32'(cfg_chan) < 32'(Channels);
    assign xfer    = cfg_valid & cfg_ready;
    assign apply   = |ld;

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= CFG_IDLE;
            pend_chan_q <= '0;
            pend_incr_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_chan_q <= pend_chan_d;
            pend_incr_q <= pend_incr_d;
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        state_d     = state_q;
        pend_chan_d = pend_chan_q;
        pend_incr_d = pend_incr_q;
        case (state_q)
            CFG_IDLE: begin
                if (cfg_valid) begin
                    pend_chan_d = cfg_chan;
                    pend_incr_d = cfg_incr;
                    state_d     = chan_ok ? CFG_PEND : CFG_DONE;
                end
            end
            CFG_PEND: begin
                if (apply) begin
                    state_d = CFG_DONE;
                end
            end
            CFG_DONE: state_d = CFG_IDLE;
            default:  state_d = CFG_IDLE;
        endcase
    end

    // ------------------------------------------------------------------ outputs
    always_comb begin
        cfg_ready = (state_q == CFG_IDLE);
    end

    // ----------------------------------------------------------------- channels
    for (genvar c = 0; c < Channels; c++) begin : g_chan
        // Load strobe goes only to the targeted channel, and only at its wrap point
        assign ld[c] = (state_q == CFG_PEND) && (pend_chan_q == ChanBits'(c)) && wrap_ok[c];

        frac_div_chan #(
            .Width (Width),
            .Incr  (Incr)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .en      (en[c]),
            .sync    (sync),
            .ld      (ld[c]),
            .ld_incr (pend_incr_q),
            .tick    (tick[c]),
            .out     (out[c]),
            .wrap_ok (wrap_ok[c])
        );
    end

    // xfer is implied by the IDLE->PEND/DONE transition; kept as a named term
    // so the handshake reads clearly in waveforms.
    logic xfer_unused;
    assign xfer_unused = xfer;

endmodule : frac_div_multi
`default_nettype wire
